// File: rtl/result_bcd_unpack.sv
// Snapshots the pi engine's base-1000 limb vector, converts each limb to three BCD digits with a
// sequential double-dabble, and serves the digit buffer through a registered read port.
// Optional macro: BCD_LEADZERO_BLANK_EN blanks leading zeros of the integer limb.
module result_bcd_unpack #(
  parameter int unsigned L      = 10,
  parameter int unsigned N      = 10,
  parameter int unsigned DIGITS = 3 * L
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [L*N-1:0] i_sum,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_ovf,
  input  logic [7:0]     i_rd_addr,
  output logic [3:0]     o_rd_digit
);

  localparam int unsigned KW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [2:0] {StIdle, StLoad, StShift, StStore, StDone} state_e;

  state_e         r_state;
  logic [L*N-1:0] r_shadow;
  logic [KW-1:0]  r_k;
  logic [N-1:0]   r_bin;
  logic [11:0]    r_bcd;
  logic [3:0]     r_cnt;
  logic           r_limb_ovf;
  logic [3:0]     r_buf [DIGITS];

  logic [N-1:0]    w_limb;
  logic [11:0]     w_adj;
  logic [N+11:0]   w_shift;
  logic [3:0]      w_hun, w_ten, w_uni;
  logic [3:0]      w_rd;

  always_comb begin
    w_limb = '0;
    for (int k = 0; k < L; k++) begin
      if (r_k == KW'(k)) w_limb = r_shadow[N*k +: N];
    end
  end

  // Add-3 correction on every nibble before the shift.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 3; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    w_shift = {w_adj, r_bin} << 1;
  end

  always_comb begin
    w_hun = r_bcd[11:8];
    w_ten = r_bcd[7:4];
    w_uni = r_bcd[3:0];
    if (r_limb_ovf) begin
      w_hun = 4'd9;
      w_ten = 4'd9;
      w_uni = 4'd9;
    end
`ifdef BCD_LEADZERO_BLANK_EN
    else if (r_k == KW'(L - 1) && w_hun == 4'd0) begin
      w_hun = 4'hF;
      if (w_ten == 4'd0) w_ten = 4'hF;
    end
`endif
  end

  always_comb begin
    w_rd = 4'hF;
    for (int i = 0; i < DIGITS; i++) begin
      if (i_rd_addr == 8'(i)) w_rd = r_buf[i];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= StIdle;
      r_shadow   <= '0;
      r_k        <= '0;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_limb_ovf <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_ovf      <= 1'b0;
      for (int i = 0; i < DIGITS; i++) r_buf[i] <= '0;
    end else begin
      // Flags follow the state one edge later so busy and done never overlap.
      o_busy <= r_state inside {StLoad, StShift, StStore};
      o_done <= (r_state == StDone);
      unique case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            r_shadow <= i_sum;
            r_k      <= KW'(L - 1);
            o_ovf    <= 1'b0;
            o_done   <= 1'b0;
            r_state  <= StLoad;
          end
        end
        StLoad: begin
          r_bin      <= w_limb;
          r_bcd      <= '0;
          r_cnt      <= '0;
          r_limb_ovf <= (w_limb > N'(999));
          r_state    <= StShift;
        end
        StShift: begin
          r_bcd <= w_shift[N+11:N];
          r_bin <= w_shift[N-1:0];
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd9) r_state <= StStore;
        end
        StStore: begin
          for (int j = 0; j < L; j++) begin
            if (r_k == KW'(j)) begin
              r_buf[3*(L-1-j)]     <= w_hun;
              r_buf[3*(L-1-j) + 1] <= w_ten;
              r_buf[3*(L-1-j) + 2] <= w_uni;
            end
          end
          if (r_limb_ovf) o_ovf <= 1'b1;
          if (r_k == '0) begin
            r_state <= StDone;
          end else begin
            r_k     <= r_k - KW'(1);
            r_state <= StLoad;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) o_rd_digit <= '0;
    else        o_rd_digit <= w_rd;
  end

endmodule

// File: tb/tb_result_bcd_unpack.sv
// Self-checking bench for result_bcd_unpack: directed and random snapshots against a
// divide/modulo digit model. Honours BCD_LEADZERO_BLANK_EN in the model.
module tb_result_bcd_unpack;
  localparam int L = 10;
  localparam int N = 10;
  localparam int D = 3 * L;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [L*N-1:0] sum = '0;
  logic           busy, done, ovf;
  logic [7:0]     rd_addr = '0;
  logic [3:0]     rd_digit;

  int         n_checks = 0;
  int         n_pass = 0;
  int         lim [L];
  logic [3:0] exp_dig [D];
  logic       exp_ovf;

  always #5 clk = ~clk;

  result_bcd_unpack #(.L(L), .N(N)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_sum      (sum),
    .o_busy     (busy),
    .o_done     (done),
    .o_ovf      (ovf),
    .i_rd_addr  (rd_addr),
    .o_rd_digit (rd_digit)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Reference: digits by plain decimal arithmetic on each limb.
  task automatic model();
    int h, t, u, base;
    exp_ovf = 1'b0;
    for (int k = 0; k < L; k++) begin
      base = 3 * (L - 1 - k);
      if (lim[k] > 999) begin
        exp_ovf = 1'b1;
        h = 9; t = 9; u = 9;
      end else begin
        h = lim[k] / 100;
        t = (lim[k] / 10) % 10;
        u = lim[k] % 10;
`ifdef BCD_LEADZERO_BLANK_EN
        if (k == L - 1 && h == 0) begin
          h = 15;
          if (t == 0) t = 15;
        end
`endif
      end
      exp_dig[base]     = 4'(h);
      exp_dig[base + 1] = 4'(t);
      exp_dig[base + 2] = 4'(u);
    end
  endtask

  task automatic pack();
    for (int k = 0; k < L; k++) sum[N*k +: N] = N'(lim[k]);
  endtask

  // Pulses start, optionally re-pulses it mid-conversion, and measures the done latency.
  task automatic run(input string tag, input int inject_at);
    int   n;
    logic both, b1;
    pack();
    start = 1'b1;
    step();
    start = 1'b0;
    check($sformatf("%s_done_clr", tag), done, 1'b0);
    n = 0; both = 1'b0; b1 = 1'b0;
    while (n < 300 && !done) begin
      if (n == inject_at) begin
        sum   = ~sum;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
      n++;
      if (n == 1) b1 = busy;
      if (busy && done) both = 1'b1;
    end
    start = 1'b0;
    check($sformatf("%s_busy_rise", tag), b1, 1'b1);
    check($sformatf("%s_latency", tag), n, 121);
    check($sformatf("%s_excl", tag), both, 1'b0);
    check($sformatf("%s_busy_end", tag), busy, 1'b0);
    model();
    check($sformatf("%s_ovf", tag), ovf, exp_ovf);
  endtask

  task automatic check_buf(input string tag);
    for (int a = 0; a < D; a++) begin
      rd_addr = 8'(a);
      step();
      check($sformatf("%s_d%0d", tag, a), rd_digit, exp_dig[a]);
    end
    rd_addr = 8'd200;
    step();
    check($sformatf("%s_blank", tag), rd_digit, 4'hF);
  endtask

  initial begin
    // Reset
    rst = 1'b0;
    step();
    step();
    check("rst_hold_digit", rd_digit, 4'h0);
    rst = 1'b1;
    step();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    for (int i = 0; i < D; i++) exp_dig[i] = 4'h0;
    check_buf("rst");

    // Pi snapshot
    lim = '{383, 643, 462, 238, 793, 589, 653, 592, 141, 3};
    run("pi", -1);
    check_buf("pi");

    // Overflow, then clear
    for (int k = 0; k < L; k++) lim[k] = 0;
    lim[5] = 1023;
    run("ovf", -1);
    check_buf("ovf");
    lim[5] = 0;
    run("zero", -1);
    check_buf("zero");

    // Random snapshots
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < L; k++) begin
        if ($urandom_range(0, 7) == 0) lim[k] = int'($urandom_range(1000, 1023));
        else                           lim[k] = int'($urandom_range(0, 999));
      end
      run($sformatf("rnd%0d", r), -1);
      check_buf($sformatf("rnd%0d", r));
    end

    // Start while busy: second pulse must be ignored
    for (int k = 0; k < L; k++) lim[k] = int'($urandom_range(0, 999));
    run("inj", 20);
    check_buf("inj");

    // Reset mid-operation; integer limb overflows so ovf is already set by cycle 50
    for (int k = 0; k < L; k++) lim[k] = int'($urandom_range(0, 999));
    lim[L-1] = 1010;
    pack();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (49) step();
    check("mid_ovf_set", ovf, 1'b1);
    rst = 1'b0;
    step();
    check("mid_busy", busy, 1'b0);
    check("mid_done", done, 1'b0);
    check("mid_ovf", ovf, 1'b0);
    check("mid_digit", rd_digit, 4'h0);
    rst = 1'b1;
    for (int i = 0; i < D; i++) exp_dig[i] = 4'h0;
    check_buf("mid_clr");
    for (int k = 0; k < L; k++) lim[k] = int'($urandom_range(0, 999));
    run("fresh", -1);
    check_buf("fresh");

    // Read latency: new address shows only after the next edge
    for (int a = 0; a < D; a++) begin
      rd_addr = 8'(a);
      #2;
      check($sformatf("lat_old%0d", a), rd_digit, (a == 0) ? 4'hF : exp_dig[a-1]);
      step();
      check($sformatf("lat_new%0d", a), rd_digit, exp_dig[a]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/result_bcd_unpack.md
# result_bcd_unpack

Downstream consumer of the Machin-series pi engine. Snapshots the engine's flat result vector (L words of N bits, each a base-1000 limb, word L-1 holding the integer part), converts each limb to three BCD digits with a sequential double-dabble, and holds the 3·L digits in a flop buffer. The VGA character generator reads the buffer through a registered random-access port.

## Interface
- `L`, default 10: number of result limbs; must match the engine.
- `N`, default 10: limb width in bits; fixed at 10, since limbs are 0..999.
- `DIGITS`, default 3*L: buffer depth in digits; derived, do not override.
- `clk`, input, 1: posedge clock for all state.
- `rst`, input, 1: reset, synchronous, active-low.
- `start`, input, 1: one-cycle request to snapshot `sum` and convert. Asserted by the system once the engine is in its END state.
- `sum`, input, L*N: engine result; limb k is `sum[N*k +: N]`.
- `busy`, output, 1: conversion in progress.
- `done`, output, 1: buffer holds a complete conversion. Held until the next accepted `start` or reset.
- `ovf`, output, 1: sticky flag; at least one limb of the last snapshot exceeded 999.
- `rd_addr`, input, 8: digit index. 0 is the most significant digit of limb L-1.
- `rd_digit`, output, 4: registered digit at `rd_addr`.

## Operation
- Each snapshot is converted in full. Partial re-conversion is not supported.
- FSM states are IDLE, LOAD, SHIFT, STORE and DONE. Reset enters IDLE.
- **IDLE / DONE:** `start` = 1 does the following:
  - latches all of `sum` into a shadow register;
  - sets limb index to L-1;
  - clears `ovf` and `done`;
  - moves to LOAD.
- **`start` during LOAD, SHIFT or STORE:** ignored, with no effect on state or the snapshot.
- **LOAD:**
  - copies the shadow limb at the current index into a 10-bit shift register;
  - clears the 12-bit BCD accumulator;
  - sets the shift counter to 0;
  - moves to SHIFT.
- **SHIFT, 10 cycles:**
  - each cycle, every BCD nibble ≥ 5 gets +3;
  - then {bcd, bin} shifts left by 1;
  - the counter increments;
  - after the 10th shift, moves to STORE.
- **STORE:**
  - writes hundreds, tens and units digits to buffer positions 3·(L-1-k), +1 and +2, where k is the limb index;
  - a limb value > 999 (detected at LOAD and carried as a flag) writes 9,9,9 instead and sets `ovf`;
  - if k = 0, moves to DONE; otherwise decrements k and moves to LOAD.
- **Read port:**
  - `rd_digit` ← buffer[`rd_addr`] on every clock, in every state;
  - `rd_addr` ≥ DIGITS returns 4'hF, the blank code;
  - reads during `busy` return the current buffer, mixing new digits and old ones not yet overwritten. This is the accepted behaviour.
- **Reset:** `rst` = 0 at any clock, including mid-conversion, has the following effect:
  - FSM to IDLE;
  - `busy` = 0, `done` = 0, `ovf` = 0, `rd_digit` = 0;
  - all buffer digits = 0;
  - shadow register = 0.

## Timing
- `start` is sampled at edge T0. `busy` = 1 from T0+1.
- Each limb takes 12 cycles: LOAD 1 + SHIFT 10 + STORE 1.
- The buffer digits of limb k update at the STORE edge.
- `done` = 1 and `busy` = 0 from edge T0 + 12·L + 1. With L = 10 this is T0 + 121.
- `busy` and `done` are never high together.
- Read latency is 1 cycle: the `rd_addr` applied before edge T appears on `rd_digit` after T.
- `start` and `rst` = 0 in the same cycle: reset wins.
- `start` in the same cycle as the final STORE: ignored. The FSM is not yet in DONE.

## Configuration
- Macro: `BCD_LEADZERO_BLANK_EN`.
- **Defined:**
  - leading zero digits of limb L-1 (the integer part) are stored as 4'hF (blank);
  - the units digit of limb L-1 is never blanked;
  - all other limbs are unaffected.
  - Example: integer limb 3 stores F,F,3.
- **Undefined:** all digits are stored literally; limb 3 stores 0,0,3.
- Cycle timing is identical either way.

## Test plan
- **Reset values:** hold `rst` = 0 for 2 cycles, then release. `busy` = `done` = `ovf` = 0. Every `rd_addr` 0..29 gives `rd_digit` = 0, and `rd_addr` = 200 gives 4'hF.
- **Pi snapshot:** L = 10, limbs 9..0 = 3, 141, 592, 653, 589, 793, 238, 462, 643, 383, then `start`.
  - `done` rises exactly 121 cycles after the start edge.
  - Digits 2..29 read 3141592653589793238462643383.
  - Digits 0..1 read 0,0 without the macro and F,F with it.
- **Overflow:** limb 5 = 1023, all other limbs 0. Digits 12..14 read 9,9,9, `ovf` = 1, and all other digits read 0. A second `start` with all limbs 0 clears `ovf`.
- **Start while busy:** pulse `start` 20 cycles into a conversion with a different `sum`. The first snapshot's digits result, `done` still arrives at T0 + 121, and there is no restart.
- **Reset mid-operation:** `rst` = 0 at cycle 50 of a conversion. Next cycle: `busy` = 0 and all digits 0. A fresh `start` then completes normally in 121 cycles.
- **Read latency:** after `done`, step `rd_addr` 0,1,2,… one per cycle. `rd_digit` tracks with exactly 1-cycle lag.
